// File: rtl/mux_scan_seq_pkg.sv
// Shared constants and FSM encoding for the mux scan sequencer.
// Widths are fixed by the 16-to-1 byte mux this block feeds.
package mux_scan_seq_pkg;

    localparam int WIDTH = 8;
    localparam int N_CH  = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_seq_if.sv
// Downstream (channel, byte) stream with a valid/ready handshake.
// The sequencer drives the master side; the consumer uses the slave side.
interface mux_scan_seq_if;
    import mux_scan_seq_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] out_chan;
    logic [WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_chan,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_chan,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/mux_scan_seq_next_en_finder.sv
// Combinational search for the lowest enabled channel at or above (incl=1)
// or strictly above (incl=0) a given index.
module next_en_finder
    import mux_scan_seq_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             incl,
    output logic [SEL_W-1:0] nxt,
    output logic             found
);

    // Scan from the top down so the lowest qualifying index is the last one written.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (incl ? (i >= int'(cur)) : (i > int'(cur)))) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_seq.sv
// Byte register bank feeding a 16-to-1 mux, plus a sequencer that walks the
// enabled channels in ascending order and streams the mux result downstream.
module mux_scan_seq
    import mux_scan_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7,
    output logic [WIDTH-1:0] q8,
    output logic [WIDTH-1:0] q9,
    output logic [WIDTH-1:0] q10,
    output logic [WIDTH-1:0] q11,
    output logic [WIDTH-1:0] q12,
    output logic [WIDTH-1:0] q13,
    output logic [WIDTH-1:0] q14,
    output logic [WIDTH-1:0] q15,
    output logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] mux_result,
    input  logic             start,
    input  logic [N_CH-1:0]  en_mask,
    mux_scan_seq_if.master   stream,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [N_CH-1:0]  mask_q;
    logic [N_CH-1:0]  mask_nxt;
    logic [WIDTH-1:0] bank [N_CH];

    logic [SEL_W-1:0] first_idx;
    logic             first_found;
    logic [SEL_W-1:0] next_idx;
    logic             next_found;

    next_en_finder u_first (
        .mask  (en_mask),
        .cur   ('0),
        .incl  (1'b1),
        .nxt   (first_idx),
        .found (first_found)
    );

    next_en_finder u_next (
        .mask  (mask_q),
        .cur   (sel),
        .incl  (1'b0),
        .nxt   (next_idx),
        .found (next_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_en) begin
            bank[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= '0;
            mask_q <= '0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            mask_q <= mask_nxt;
        end
    end

    // An empty mask skips straight to DONE so the requester still sees completion.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        mask_nxt  = mask_q;
        case (state)
            IDLE: begin
                if (start) begin
                    mask_nxt = en_mask;
                    if (first_found) begin
                        sel_nxt   = first_idx;
                        state_nxt = SCAN;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            SCAN: begin
                if (stream.out_ready) begin
                    if (next_found) begin
                        sel_nxt = next_idx;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign stream.out_valid = (state == SCAN);
    assign stream.out_chan  = sel;
    assign stream.out_data  = mux_result;
    assign busy             = (state == SCAN);
    assign done             = (state == DONE);

    assign q0  = bank[0];
    assign q1  = bank[1];
    assign q2  = bank[2];
    assign q3  = bank[3];
    assign q4  = bank[4];
    assign q5  = bank[5];
    assign q6  = bank[6];
    assign q7  = bank[7];
    assign q8  = bank[8];
    assign q9  = bank[9];
    assign q10 = bank[10];
    assign q11 = bank[11];
    assign q12 = bank[12];
    assign q13 = bank[13];
    assign q14 = bank[14];
    assign q15 = bank[15];

endmodule
